// File: rtl/sram_arbiter.sv
// Two-master arbiter for an asynchronous SRAM on a split data bus (m0 = data, m1 = fetch).
// Define SRAM_ARB_ROUND_ROBIN_EN to alternate grants under contention; default is m0 fixed priority.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [19:0] m0_addr,
  input  logic [3:0]  m0_be_n,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [19:0] m1_addr,
  input  logic [3:0]  m1_be_n,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic [19:0] ram_addr,
  output logic [3:0]  ram_be_n,
  output logic        ram_we,
  output logic [31:0] ram_data_out,
  input  logic [31:0] ram_data_in,
  output logic        busy
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    READ,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic [19:0] ram_addr_q, ram_addr_d;
  logic [3:0]  ram_be_n_q, ram_be_n_d;
  logic        ram_we_q, ram_we_d;
  logic [31:0] ram_data_out_q, ram_data_out_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        m0_ack_q, m0_ack_d;
  logic        m1_ack_q, m1_ack_d;
  logic        busy_q, busy_d;
  logic        pick_m1;

  // Grant selection, only consulted when at least one request is present
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;
  assign pick_m1 = (m0_req && m1_req) ? rr_q : m1_req;
`else
  assign pick_m1 = ~m0_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      gnt_q          <= 1'b0;
      ram_addr_q     <= '0;
      ram_be_n_q     <= 4'hF;
      ram_we_q       <= 1'b0;
      ram_data_out_q <= '0;
      m0_rdata_q     <= '0;
      m1_rdata_q     <= '0;
      m0_ack_q       <= 1'b0;
      m1_ack_q       <= 1'b0;
      busy_q         <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      rr_q           <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      gnt_q          <= gnt_d;
      ram_addr_q     <= ram_addr_d;
      ram_be_n_q     <= ram_be_n_d;
      ram_we_q       <= ram_we_d;
      ram_data_out_q <= ram_data_out_d;
      m0_rdata_q     <= m0_rdata_d;
      m1_rdata_q     <= m1_rdata_d;
      m0_ack_q       <= m0_ack_d;
      m1_ack_q       <= m1_ack_d;
      busy_q         <= busy_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      rr_q           <= rr_d;
`endif
    end
  end

  // Next-state and registered-output values; request fields are latched once in IDLE
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    gnt_d          = gnt_q;
    ram_addr_d     = ram_addr_q;
    ram_be_n_d     = ram_be_n_q;
    ram_we_d       = 1'b0;
    ram_data_out_d = ram_data_out_q;
    m0_rdata_d     = m0_rdata_q;
    m1_rdata_d     = m1_rdata_q;
    m0_ack_d       = 1'b0;
    m1_ack_d       = 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    rr_d           = rr_q;
`endif
    case (state_q)
      IDLE: begin
        ram_be_n_d = 4'hF;
        if (m0_req || m1_req) begin
          gnt_d          = pick_m1;
          ram_addr_d     = pick_m1 ? m1_addr  : m0_addr;
          ram_be_n_d     = pick_m1 ? m1_be_n  : m0_be_n;
          ram_data_out_d = pick_m1 ? m1_wdata : m0_wdata;
          cnt_d          = '0;
          state_d        = (pick_m1 ? m1_we : m0_we) ? SETUP : READ;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          rr_d           = ~pick_m1;
`endif
        end
      end
      SETUP: begin
        ram_we_d = 1'b1;
        state_d  = STROBE;
      end
      STROBE: begin
        if (cnt_q == LAST_CNT) begin
          state_d  = HOLD;
          m0_ack_d = ~gnt_q;
          m1_ack_d = gnt_q;
        end else begin
          cnt_d    = cnt_q + 3'd1;
          ram_we_d = 1'b1;
        end
      end
      READ: begin
        if (cnt_q == LAST_CNT) begin
          state_d  = DONE;
          m0_ack_d = ~gnt_q;
          m1_ack_d = gnt_q;
          if (gnt_q) begin
            m1_rdata_d = ram_data_in;
          end else begin
            m0_rdata_d = ram_data_in;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      HOLD, DONE: begin
        state_d    = IDLE;
        ram_be_n_d = 4'hF;
      end
      default: begin
        state_d    = IDLE;
        ram_be_n_d = 4'hF;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign ram_addr     = ram_addr_q;
  assign ram_be_n     = ram_be_n_q;
  assign ram_we       = ram_we_q;
  assign ram_data_out = ram_data_out_q;
  assign m0_rdata     = m0_rdata_q;
  assign m1_rdata     = m1_rdata_q;
  assign m0_ack       = m0_ack_q;
  assign m1_ack       = m1_ack_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: per-cycle vector table on a WAIT_CYCLES=1 instance,
// plus contention and WAIT_CYCLES=3 sequences.
module tb_sram_arbiter;

  typedef struct packed {
    logic        rst_n;
    logic        m0_req;
    logic        m0_we;
    logic [19:0] m0_addr;
    logic [3:0]  m0_be_n;
    logic [31:0] m0_wdata;
    logic        m1_req;
    logic        m1_we;
    logic [19:0] m1_addr;
    logic [3:0]  m1_be_n;
    logic [31:0] m1_wdata;
    logic [31:0] din;
  } in_t;

  typedef struct packed {
    logic [19:0] addr;
    logic [3:0]  be_n;
    logic        we;
    logic [31:0] dout;
    logic        ack0;
    logic        ack1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        busy;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [19:0] m0_addr, m1_addr;
  logic [3:0]  m0_be_n, m1_be_n;
  logic [31:0] m0_wdata, m1_wdata, ram_data_in;

  logic [31:0] m0_rdata, m1_rdata, ram_data_out;
  logic        m0_ack, m1_ack, ram_we, busy;
  logic [19:0] ram_addr;
  logic [3:0]  ram_be_n;

  logic [31:0] w3_m0_rdata, w3_m1_rdata, w3_ram_data_out;
  logic        w3_m0_ack, w3_m1_ack, w3_ram_we, w3_busy;
  logic [19:0] w3_ram_addr;
  logic [3:0]  w3_ram_be_n;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  sram_arbiter #(.WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be_n(m0_be_n),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be_n(m1_be_n),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .ram_addr(ram_addr), .ram_be_n(ram_be_n), .ram_we(ram_we),
    .ram_data_out(ram_data_out), .ram_data_in(ram_data_in), .busy(busy)
  );

  sram_arbiter #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be_n(m0_be_n),
    .m0_wdata(m0_wdata), .m0_rdata(w3_m0_rdata), .m0_ack(w3_m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be_n(m1_be_n),
    .m1_wdata(m1_wdata), .m1_rdata(w3_m1_rdata), .m1_ack(w3_m1_ack),
    .ram_addr(w3_ram_addr), .ram_be_n(w3_ram_be_n), .ram_we(w3_ram_we),
    .ram_data_out(w3_ram_data_out), .ram_data_in(ram_data_in), .busy(w3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t i);
    rst_n       = i.rst_n;
    m0_req      = i.m0_req;
    m0_we       = i.m0_we;
    m0_addr     = i.m0_addr;
    m0_be_n     = i.m0_be_n;
    m0_wdata    = i.m0_wdata;
    m1_req      = i.m1_req;
    m1_we       = i.m1_we;
    m1_addr     = i.m1_addr;
    m1_be_n     = i.m1_be_n;
    m1_wdata    = i.m1_wdata;
    ram_data_in = i.din;
  endtask

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    vecs.push_back(v);
  endtask

  // Inputs held for one cycle; outputs checked just after the closing edge
  task automatic apply_row(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.i);
    @(posedge clk);
    #1;
    check($sformatf("row%0d ram_addr", idx),     32'(ram_addr),     32'(v.o.addr));
    check($sformatf("row%0d ram_be_n", idx),     32'(ram_be_n),     32'(v.o.be_n));
    check($sformatf("row%0d ram_we", idx),       32'(ram_we),       32'(v.o.we));
    check($sformatf("row%0d ram_data_out", idx), ram_data_out,      v.o.dout);
    check($sformatf("row%0d m0_ack", idx),       32'(m0_ack),       32'(v.o.ack0));
    check($sformatf("row%0d m1_ack", idx),       32'(m1_ack),       32'(v.o.ack1));
    check($sformatf("row%0d m0_rdata", idx),     m0_rdata,          v.o.rd0);
    check($sformatf("row%0d m1_rdata", idx),     m1_rdata,          v.o.rd1);
    check($sformatf("row%0d busy", idx),         32'(busy),         32'(v.o.busy));
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(in_t'{1'b0, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Both masters request reads continuously; record the order of acks
  task automatic contention();
    logic got [4];
    logic exp_g [4];
    int   n;
    n = 0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
`else
    exp_g[0] = 1'b0; exp_g[1] = 1'b0; exp_g[2] = 1'b0; exp_g[3] = 1'b0;
`endif
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 20'h00100; m0_be_n = 4'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 20'h00200; m1_be_n = 4'h0;
    ram_data_in = 32'h0000_0077;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(posedge clk);
      #1;
      if (m0_ack || m1_ack) begin
        check("contention one ack only", 32'(m0_ack & m1_ack), 32'h0);
        check("contention ram_addr", 32'(ram_addr), m1_ack ? 32'h200 : 32'h100);
        got[n] = m1_ack;
        n++;
      end
    end
    check("contention ack count", 32'(n), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < n) check($sformatf("contention grant%0d is_m1", k), 32'(got[k]), 32'(exp_g[k]));
    end
    @(negedge clk);
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  // WAIT_CYCLES=3 read: READ cycles 1..3, ack in cycle 4, IDLE in cycle 5
  task automatic long_read();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 20'h00055; m0_be_n = 4'h0; m0_wdata = 32'h0;
    ram_data_in = 32'h0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("w3 cyc%0d busy", k),     32'(w3_busy),     32'(k <= 4));
      check($sformatf("w3 cyc%0d m0_ack", k),   32'(w3_m0_ack),   32'(k == 4));
      check($sformatf("w3 cyc%0d m1_ack", k),   32'(w3_m1_ack),   32'h0);
      check($sformatf("w3 cyc%0d ram_we", k),   32'(w3_ram_we),   32'h0);
      check($sformatf("w3 cyc%0d ram_be_n", k), 32'(w3_ram_be_n), (k <= 4) ? 32'h0 : 32'hF);
      check($sformatf("w3 cyc%0d m0_rdata", k), w3_m0_rdata,      (k >= 4) ? 32'h3333_3333 : 32'h0);
      if (k <= 4) check($sformatf("w3 cyc%0d ram_addr", k), 32'(w3_ram_addr), 32'h55);
      @(negedge clk);
      ram_data_in = (k == 3) ? 32'h3333_3333 : 32'(k);
      m0_req      = (k <= 3);
    end
  endtask

  initial begin
    drive(in_t'{1'b0, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 32'h0});

    // in: rst, m0{req,we,addr,be_n,wdata}, m1{req,we,addr,be_n,wdata}, din
    // out: addr, be_n, we, dout, ack0, ack1, rd0, rd1, busy
    add(in_t'{1'b0, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 32'h0},
        out_t'{20'h0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0});
    add(in_t'{1'b1, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 32'h0},
        out_t'{20'h0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0});
    // m1 read of 0x00010
    add(in_t'{1'b1, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 1'b1, 1'b0, 20'h00010, 4'h0, 32'h0, 32'h0},
        out_t'{20'h00010, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1});
    add(in_t'{1'b1, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 1'b1, 1'b0, 20'h00010, 4'h0, 32'h0, 32'h1234_5678},
        out_t'{20'h00010, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h1234_5678, 1'b1});
    add(in_t'{1'b1, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 32'h0},
        out_t'{20'h00010, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 1'b0});
    // m0 write 0xCAFEBABE to 0x00020; req and fields disturbed after grant
    add(in_t'{1'b1, 1'b1, 1'b1, 20'h00020, 4'hC, 32'hCAFE_BABE, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 32'hDEAD_BEEF},
        out_t'{20'h00020, 4'hC, 1'b0, 32'hCAFE_BABE, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 1'b1});
    add(in_t'{1'b1, 1'b0, 1'b1, 20'h00099, 4'h3, 32'h0BAD_F00D, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 32'hDEAD_BEEF},
        out_t'{20'h00020, 4'hC, 1'b1, 32'hCAFE_BABE, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 1'b1});
    add(in_t'{1'b1, 1'b0, 1'b1, 20'h00099, 4'h3, 32'h0BAD_F00D, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 32'hDEAD_BEEF},
        out_t'{20'h00020, 4'hC, 1'b0, 32'hCAFE_BABE, 1'b1, 1'b0, 32'h0, 32'h1234_5678, 1'b1});
    add(in_t'{1'b1, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 32'h0},
        out_t'{20'h00020, 4'hF, 1'b0, 32'hCAFE_BABE, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 1'b0});
    // m0 read of 0x00030; m1_rdata must be untouched
    add(in_t'{1'b1, 1'b1, 1'b0, 20'h00030, 4'h0, 32'h0, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 32'h0},
        out_t'{20'h00030, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 1'b1});
    add(in_t'{1'b1, 1'b1, 1'b0, 20'h00030, 4'h0, 32'h0, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 32'hA5A5_0F0F},
        out_t'{20'h00030, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hA5A5_0F0F, 32'h1234_5678, 1'b1});
    add(in_t'{1'b1, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 32'h0},
        out_t'{20'h00030, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, 32'hA5A5_0F0F, 32'h1234_5678, 1'b0});
    // m1 write to 0x00040, reset asserted during STROBE
    add(in_t'{1'b1, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 1'b1, 1'b1, 20'h00040, 4'h0, 32'h1111_2222, 32'h0},
        out_t'{20'h00040, 4'h0, 1'b0, 32'h1111_2222, 1'b0, 1'b0, 32'hA5A5_0F0F, 32'h1234_5678, 1'b1});
    add(in_t'{1'b1, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 1'b1, 1'b1, 20'h00040, 4'h0, 32'h1111_2222, 32'h0},
        out_t'{20'h00040, 4'h0, 1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'hA5A5_0F0F, 32'h1234_5678, 1'b1});
    add(in_t'{1'b0, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 1'b1, 1'b1, 20'h00040, 4'h0, 32'h1111_2222, 32'h0},
        out_t'{20'h0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0});
    add(in_t'{1'b1, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 32'h0},
        out_t'{20'h0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0});
    add(in_t'{1'b1, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 1'b0, 1'b0, 20'h0, 4'hF, 32'h0, 32'h0},
        out_t'{20'h0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0});

    foreach (vecs[idx]) apply_row(vecs[idx], idx);

    contention();
    long_read();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning SRAM strobe/access width in clk cycles (legal range 1..7).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports m0_req/m1_req  input  1  each  access request; m0 is the data port, m1 is instruction fetch.
REQ-005 SHALL have ports mN_we  input  1, mN_addr  input  20, mN_be_n  input  4, mN_wdata  input  32 for N=0,1.
REQ-006 SHALL have ports mN_rdata  output  32 and mN_ack  output  1 for N=0,1.
REQ-007 SHALL have ports ram_addr  output  20, ram_be_n  output  4, ram_we  output  1, ram_data_out  output  32, ram_data_in  input  32 (split SRAM bus; top level derives we_n/oe_n/tristate from ram_we).
REQ-008 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-009 SHALL implement states IDLE, SETUP, STROBE, HOLD (write path) and READ, DONE (read path).
REQ-010 In IDLE, when any req is high, SHALL grant one master, register its addr/be_n/wdata/we onto ram_* outputs and move to SETUP (we=1) or READ (we=0) next cycle.
REQ-011 Without the configuration macro, SHALL grant by fixed priority: m0 over m1.
REQ-012 Read timing (cycle 0 = IDLE with req): ram_addr valid cycles 1..WAIT_CYCLES (READ), ram_data_in captured at end of last READ cycle, mN_ack pulses with mN_rdata valid in cycle WAIT_CYCLES+1 (DONE).
REQ-013 Write timing: SETUP cycle 1 with ram_we=0; STROBE cycles 2..WAIT_CYCLES+1 with ram_we=1; HOLD cycle WAIT_CYCLES+2 with ram_we=0, addr/data held, mN_ack pulsed.
REQ-014 ram_addr, ram_be_n, ram_data_out SHALL remain stable from cycle 1 until the ack cycle inclusive.
REQ-015 DONE and HOLD SHALL return to IDLE unconditionally; a req high in IDLE is always a new request.
REQ-016 mN_ack SHALL be a single-cycle pulse to the granted master only; the other master's ack stays 0.
REQ-017 Masters SHALL hold req and request fields until ack; deassertion of req mid-transaction SHALL be ignored and the transaction completed with ack.
REQ-018 mN_rdata SHALL hold its last captured value until the next read by that master; writes SHALL not alter it.
REQ-019 ram_we SHALL never be high outside STROBE; ram_be_n SHALL be 4'hF in IDLE.

Reset
REQ-020 With rst_n=0 at a rising edge, SHALL enter IDLE: ram_we=0, ram_addr=0, ram_be_n=4'hF, ram_data_out=0, both ack=0, both rdata=0, busy=0, round-robin pointer = m0.
REQ-021 Reset mid-transaction SHALL abort it: ram_we low next edge, no ack issued.

Configuration
REQ-022 Macro SRAM_ARB_ROUND_ROBIN_EN: when defined, simultaneous requests SHALL alternate grant, pointer toggling after each granted transaction to favour the other master; single requests granted immediately. When undefined, fixed priority per REQ-011, no pointer logic.

Verification (WAIT_CYCLES=1)
REQ-023 m1 read addr 0x00010, ram_data_in=0x12345678 -> m1_ack in cycle 2, m1_rdata=0x12345678, m0_ack=0.
REQ-024 m0 write addr 0x00020, be_n=4'b1100, wdata=0xCAFEBABE -> ram_we=1 only cycle 2, ack cycle 3, ram_be_n=4'b1100 cycles 1..3.
REQ-025 m0 and m1 request together continuously (macro undefined) -> m0 granted every transaction, m1 never acked.
REQ-026 Same stimulus with SRAM_ARB_ROUND_ROBIN_EN -> grants alternate m0, m1, m0, m1.
REQ-027 rst_n low in write STROBE cycle -> ram_we=0 next edge, no ack, busy=0, state IDLE.
REQ-028 WAIT_CYCLES=3 read -> READ cycles 1..3, ack cycle 4, return to IDLE cycle 5.
